pattern_bist_driver: RTL and testbench
======================================

// Module: pattern_bist_driver
// PURPOSE
//   Drives a merged-pattern netlist and reads its outputs back. An LFSR generates STIM_W-bit vectors
//   for the pattern block's IN_* inputs. A MISR compacts the RESP_W-bit responses into a signature.
//   A start/busy/done handshake controls each run. Sits beside each pattern_NNN test_final instance
//   in the regression harness.
// PARAMETERS
//   STIM_W     15       stimulus width (pattern block input count, clock/reset excluded)
//   RESP_W     13       response width (pattern block output count)
//   CNT_W      16       vector counter width
//   RESP_LAT   1        DUT cycles from stim_o to valid resp_i; legal 0..4
//   LFSR_POLY  15'h6000 Galois right-shift tap mask (x^15+x^14+1)
//   MISR_POLY  13'h001B left-shift feedback mask (x^13+x^4+x^3+x+1)
// PORTS
//   blif_clk_net    in   1       single clock, rising edge
//   blif_reset_net  in   1       asynchronous, active-low reset
//   start_i         in   1       start request; sampled in IDLE only
//   num_vec_i       in   CNT_W   vectors to apply; sampled with start_i
//   seed_i          in   STIM_W  LFSR seed; sampled with start_i
//   stim_o          out  STIM_W  vector to the pattern block inputs
//   stim_valid_o    out  1       stim_o is a counted vector this cycle
//   resp_i          in   RESP_W  pattern block outputs
//   busy_o          out  1       high in RUN and FLUSH
//   done_o          out  1       one-cycle pulse at run end
//   signature_o     out  RESP_W  MISR state; held stable outside RUN/FLUSH
//   vec_cnt_o       out  CNT_W   vectors applied in the current or last run
// BEHAVIOUR
//   Reset (async, blif_reset_net=0) values:
//     - state=IDLE; lfsr=1; stim_o=0; stim_valid_o=0; busy_o=0; done_o=0
//     - signature_o=0; vec_cnt_o=0; vpipe=0
//   FSM states: IDLE, RUN, FLUSH, DONE.
//     IDLE -> RUN   start_i=1 and num_vec_i!=0
//       - lfsr<=seed_i; a zero seed is replaced by 1
//       - MISR<=0; vec_cnt<=0; num latched
//     IDLE -> DONE  start_i=1 and num_vec_i==0; MISR<=0, vec_cnt<=0
//     RUN
//       - stim_o=lfsr; stim_valid_o=1
//       - every edge: lfsr<=(lfsr>>1)^(lfsr[0]?LFSR_POLY:0); vec_cnt++
//       - vec_cnt==num-1 -> FLUSH (exactly num vectors applied)
//     FLUSH
//       - stim_valid_o=0; stim_o holds the last vector
//       - lasts until vpipe==0 (RESP_LAT cycles); RESP_LAT=0 goes straight to DONE
//     DONE
//       - done_o=1 for one cycle; then IDLE
//   Response alignment:
//     - vpipe[RESP_LAT-1:0] shift register of stim_valid_o
//     - MISR updates on edges where the tap is 1; tap=vpipe[RESP_LAT-1], or stim_valid_o when RESP_LAT=0
//     - update: sig<={sig[RESP_W-2:0],1'b0}^(sig[RESP_W-1]?MISR_POLY:0)^resp_i
//   Boundary conditions:
//     - start_i in RUN/FLUSH/DONE is ignored
//     - num_vec_i=2^CNT_W-1 supported; no counter wrap
//     - reset asserted mid-run aborts at once to reset values; no done_o pulse
//     - back-to-back runs: start_i in the IDLE cycle right after DONE is accepted
// STRUCTURE
//   - Shared package pattern_bist_pkg: state enum; default LFSR_POLY/MISR_POLY constants
//   - One sub-module, pattern_misr (RESP_W, MISR_POLY), ports: en, clr, d, sig
//   - LFSR, counter and FSM are inline
// TESTING
//   1. seed=0x0001, num=3, resp_i=0
//      -> stim_o 0x0001, 0x6000, 0x3000 with stim_valid_o=1 for 3 cycles
//      -> signature 0x0000; vec_cnt_o=3
//   2. RESP_LAT=1, num=2, resp_i=13'h0001 constant
//      -> MISR updates on 2 edges; signature_o=0x0003
//      -> done_o exactly 2 cycles after the last stim_valid_o
//   3. num=0 with start_i
//      -> no stim_valid_o; done_o one cycle after start; signature 0, vec_cnt_o 0
//   4. seed=0 -> first stim_o=0x0001 (zero-seed substitution)
//   5. Pulse blif_reset_net low in RUN after 5 vectors
//      -> all outputs return to reset values asynchronously; no done_o pulse
//      -> a fresh start reproduces the scenario 1 sequence
//   6. start_i held high throughout, num=4
//      -> second run starts in the IDLE cycle after done_o; signatures of both runs identical
//   Also check against a reference model:
//     - test_final as DUT, RESP_LAT=1, 1000 vectors
//     - signature_o must match the model; stim_valid_o count must equal num_vec_i

Source files
------------

// File: rtl/pattern_bist_pkg.sv
// Shared types and default polynomials for the pattern BIST driver slice.
package pattern_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } bist_state_t;

   // Galois right-shift taps for x^15+x^14+1; left-shift MISR feedback for x^13+x^4+x^3+x+1
   localparam logic [14:0] DEF_LFSR_POLY = 15'h6000;
   localparam logic [12:0] DEF_MISR_POLY = 13'h001B;

endpackage

// File: rtl/pattern_bist_if.sv
// Start/stimulus/response bundle between the regression harness and the BIST driver.
interface pattern_bist_if #(
   parameter int STIM_W = 15,
   parameter int RESP_W = 13,
   parameter int CNT_W  = 16
);
   logic              start_i;
   logic [CNT_W-1:0]  num_vec_i;
   logic [STIM_W-1:0] seed_i;
   logic [STIM_W-1:0] stim_o;
   logic              stim_valid_o;
   logic [RESP_W-1:0] resp_i;
   logic              busy_o;
   logic              done_o;
   logic [RESP_W-1:0] signature_o;
   logic [CNT_W-1:0]  vec_cnt_o;

   modport master (
      output start_i, num_vec_i, seed_i, resp_i,
      input  stim_o, stim_valid_o, busy_o, done_o, signature_o, vec_cnt_o
   );

   modport slave (
      input  start_i, num_vec_i, seed_i, resp_i,
      output stim_o, stim_valid_o, busy_o, done_o, signature_o, vec_cnt_o
   );
endinterface

// File: rtl/pattern_misr.sv
// Multiple-input signature register compacting pattern block responses.
module pattern_misr
   import pattern_bist_pkg::*;
#(
   parameter int                RESP_W    = 13,
   parameter logic [RESP_W-1:0] MISR_POLY = DEF_MISR_POLY
) (
   input  logic              blif_clk_net,
   input  logic              blif_reset_net,
   input  logic              en,
   input  logic              clr,
   input  logic [RESP_W-1:0] d,
   output logic [RESP_W-1:0] sig
);

   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= {sig[RESP_W-2:0], 1'b0} ^ (sig[RESP_W-1] ? MISR_POLY : '0) ^ d;
      end
   end

endmodule

// File: rtl/pattern_bist_driver.sv
// LFSR stimulus generator with MISR response compaction and start/busy/done control.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start_i; outputs hold results of the last run
// ST_RUN   | one counted vector per cycle on stim_o
// ST_FLUSH | stimulus stopped; waiting RESP_LAT cycles for last responses
// ST_DONE  | one-cycle done_o pulse, then back to ST_IDLE
module pattern_bist_driver
   import pattern_bist_pkg::*;
#(
   parameter int                STIM_W    = 15,
   parameter int                RESP_W    = 13,
   parameter int                CNT_W     = 16,
   parameter int                RESP_LAT  = 1,
   parameter logic [STIM_W-1:0] LFSR_POLY = DEF_LFSR_POLY,
   parameter logic [RESP_W-1:0] MISR_POLY = DEF_MISR_POLY
) (
   input  logic           blif_clk_net,
   input  logic           blif_reset_net,
   pattern_bist_if.slave  bus
);

   localparam int         VP_W       = (RESP_LAT > 0) ? RESP_LAT : 1;
   localparam logic [2:0] FLUSH_LAST = 3'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);

   bist_state_t       state;
   logic [STIM_W-1:0] lfsr;
   logic [STIM_W-1:0] lfsr_nxt;
   logic [STIM_W-1:0] seed_nz;
   logic [STIM_W-1:0] stim;
   logic              stim_valid;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  vec_cnt;
   logic [CNT_W-1:0]  rem_cnt;
   logic [2:0]        flush_cnt;
   logic [VP_W-1:0]   vpipe;
   logic              tap;
   logic              misr_clr;

   assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
   assign seed_nz  = (bus.seed_i == '0) ? STIM_W'(1) : bus.seed_i;
   assign misr_clr = (state == ST_IDLE) && bus.start_i;
   assign tap      = (RESP_LAT == 0) ? stim_valid : vpipe[VP_W-1];

   // rem_cnt counts down the vectors still to issue after the current one
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         state      <= ST_IDLE;
         lfsr       <= STIM_W'(1);
         stim       <= '0;
         stim_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         vec_cnt    <= '0;
         rem_cnt    <= '0;
         flush_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start_i) begin
                  vec_cnt <= '0;
                  if (bus.num_vec_i != '0) begin
                     state      <= ST_RUN;
                     lfsr       <= seed_nz;
                     stim       <= seed_nz;
                     stim_valid <= 1'b1;
                     busy       <= 1'b1;
                     rem_cnt    <= bus.num_vec_i - CNT_W'(1);
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               lfsr    <= lfsr_nxt;
               vec_cnt <= vec_cnt + CNT_W'(1);
               if (rem_cnt == '0) begin
                  stim_valid <= 1'b0;
                  if (RESP_LAT == 0) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state     <= ST_FLUSH;
                     flush_cnt <= FLUSH_LAST;
                  end
               end else begin
                  rem_cnt <= rem_cnt - CNT_W'(1);
                  stim    <= lfsr_nxt;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt == '0) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - 3'd1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Delays stim_valid to line up with the pattern block's response latency
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         vpipe <= '0;
      end else begin
         vpipe <= (vpipe << 1) | VP_W'(stim_valid);
      end
   end

   pattern_misr #(
      .RESP_W    (RESP_W),
      .MISR_POLY (MISR_POLY)
   ) u_misr (
      .blif_clk_net   (blif_clk_net),
      .blif_reset_net (blif_reset_net),
      .en             (tap),
      .clr            (misr_clr),
      .d              (bus.resp_i),
      .sig            (bus.signature_o)
   );

   assign bus.stim_o       = stim;
   assign bus.stim_valid_o = stim_valid;
   assign bus.busy_o       = busy;
   assign bus.done_o       = done;
   assign bus.vec_cnt_o    = vec_cnt;

endmodule

// File: tb/tb_pattern_bist_driver.sv
// Randomized self-checking bench for pattern_bist_driver against a vector-list reference model.
module tb_pattern_bist_driver;
   import pattern_bist_pkg::*;

   localparam int STIM_W   = 15;
   localparam int RESP_W   = 13;
   localparam int CNT_W    = 16;
   localparam int RESP_LAT = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pattern_bist_if #(.STIM_W(STIM_W), .RESP_W(RESP_W), .CNT_W(CNT_W)) bus ();

   pattern_bist_driver #(
      .STIM_W   (STIM_W),
      .RESP_W   (RESP_W),
      .CNT_W    (CNT_W),
      .RESP_LAT (RESP_LAT)
   ) dut (
      .blif_clk_net   (clk),
      .blif_reset_net (rst_n),
      .bus            (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int done_cnt = 0;
   int last_valid_cyc = 0;
   int done_cyc = 0;
   int start_cyc = 0;

   bit                fn_mode    = 1'b0;
   logic [RESP_W-1:0] resp_const = '0;
   logic [RESP_W-1:0] resp_q     = '0;
   logic [STIM_W-1:0] vq[$];
   logic [STIM_W-1:0] exp_q[$];

   // Stand-in for the pattern block: combinational function with one register stage
   function automatic logic [RESP_W-1:0] resp_fn(input logic [STIM_W-1:0] s);
      logic [STIM_W-1:0] t;
      t = (s * 15'd7) ^ (s >> 3);
      return t[RESP_W-1:0] ^ {11'b0, t[14:13]};
   endfunction

   always @(posedge clk) resp_q <= resp_fn(bus.stim_o);
   assign bus.resp_i = fn_mode ? resp_q : resp_const;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.stim_valid_o === 1'b1) begin
         vq.push_back(bus.stim_o);
         last_valid_cyc = cyc;
      end
      if (bus.done_o === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [STIM_W-1:0] lfsr_step(input logic [STIM_W-1:0] s);
      logic [STIM_W-1:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 15'h6000;
      return r;
   endfunction

   function automatic logic [RESP_W-1:0] misr_step(input logic [RESP_W-1:0] s, input logic [RESP_W-1:0] r);
      logic [RESP_W-1:0] n;
      n = s << 1;
      if (s[RESP_W-1]) n = n ^ 13'h001B;
      return n ^ r;
   endfunction

   // Expected vector list and final signature for one run
   task automatic model_run(input logic [STIM_W-1:0] seed, input int num, output logic [RESP_W-1:0] sig);
      logic [STIM_W-1:0] v;
      v = (seed == '0) ? STIM_W'(1) : seed;
      sig = '0;
      exp_q.delete();
      for (int i = 0; i < num; i++) begin
         exp_q.push_back(v);
         sig = misr_step(sig, fn_mode ? resp_fn(v) : resp_const);
         v = lfsr_step(v);
      end
   endtask

   task automatic wait_done(input int budget, input bit glitch, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.done_o === 1'b1) begin
            ok = 1'b1;
            done_cyc = cyc;
            break;
         end
         if (glitch) begin
            bus.start_i   = 1'($urandom_range(0, 1));
            bus.num_vec_i = CNT_W'($urandom);
            bus.seed_i    = STIM_W'($urandom);
         end
         @(negedge clk);
      end
      bus.start_i = 1'b0;
   endtask

   task automatic do_run(input string tag, input logic [STIM_W-1:0] seed, input int num, input bit glitch);
      bit ok;
      vq.delete();
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.num_vec_i = CNT_W'(num);
      bus.seed_i    = seed;
      start_cyc     = cyc;
      @(negedge clk);
      bus.start_i = 1'b0;
      wait_done(num + 20, glitch, ok);
      chk({tag, "_done_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic check_run(input string tag, input logic [STIM_W-1:0] seed, input int num);
      logic [RESP_W-1:0] sig;
      int bad;
      model_run(seed, num, sig);
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < vq.size(); i++)
         if (vq[i] !== exp_q[i]) bad++;
      chk({tag, "_valid_count"}, 32'(vq.size()), 32'(num));
      chk({tag, "_vector_errs"}, 32'(bad), 32'd0);
      chk({tag, "_signature"}, 32'(bus.signature_o), 32'(sig));
      chk({tag, "_vec_cnt"}, 32'(bus.vec_cnt_o), 32'(num));
      chk({tag, "_busy_at_done"}, 32'(bus.busy_o), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_stim"}, 32'(bus.stim_o), 32'd0);
      chk({tag, "_valid"}, 32'(bus.stim_valid_o), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
      chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
      chk({tag, "_sig"}, 32'(bus.signature_o), 32'd0);
      chk({tag, "_vec_cnt"}, 32'(bus.vec_cnt_o), 32'd0);
   endtask

   initial begin
      logic [STIM_W-1:0] s;
      logic [RESP_W-1:0] sig1, sig2, msig;
      int n, d1, v1, dc_before;
      bit ok;

      bus.start_i   = 1'b0;
      bus.num_vec_i = '0;
      bus.seed_i    = '0;

      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Scenario 1: known LFSR sequence from seed 1
      fn_mode = 1'b0; resp_const = '0;
      do_run("s1", 15'h0001, 3, 1'b0);
      chk("s1_v0", 32'(vq.size() > 0 ? vq[0] : '0), 32'h0001);
      chk("s1_v1", 32'(vq.size() > 1 ? vq[1] : '0), 32'h6000);
      chk("s1_v2", 32'(vq.size() > 2 ? vq[2] : '0), 32'h3000);
      check_run("s1", 15'h0001, 3);

      // Scenario 2: constant response, latency of done after last vector
      resp_const = 13'h0001;
      s = STIM_W'($urandom);
      do_run("s2", s, 2, 1'b0);
      chk("s2_sig_const", 32'(bus.signature_o), 32'h0003);
      chk("s2_done_lat", 32'(done_cyc - last_valid_cyc), 32'd2);
      check_run("s2", s, 2);

      // Scenario 3: zero-length run
      do_run("s3", 15'h1234, 0, 1'b0);
      chk("s3_no_valid", 32'(vq.size()), 32'd0);
      chk("s3_done_lat", 32'(done_cyc - start_cyc), 32'd1);
      chk("s3_sig", 32'(bus.signature_o), 32'd0);
      chk("s3_vec_cnt", 32'(bus.vec_cnt_o), 32'd0);

      // Scenario 4: zero seed substitution
      fn_mode = 1'b1;
      do_run("s4", '0, 5, 1'b0);
      chk("s4_first", 32'(vq.size() > 0 ? vq[0] : '0), 32'h0001);
      check_run("s4", '0, 5);

      // Scenario 5: asynchronous reset in the middle of a run
      fn_mode = 1'b0; resp_const = 13'h0155;
      vq.delete();
      @(negedge clk);
      bus.start_i = 1'b1; bus.num_vec_i = 16'd10; bus.seed_i = 15'h0001;
      @(negedge clk);
      bus.start_i = 1'b0;
      for (int i = 0; i < 30 && vq.size() < 5; i++) @(negedge clk);
      chk("s5_reached_5", 32'(vq.size() >= 5), 32'd1);
      dc_before = done_cnt;
      #2 rst_n = 1'b0;
      #1 check_reset_vals("s5_async");
      repeat (3) @(negedge clk);
      chk("s5_busy_held", 32'(bus.busy_o), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("s5_no_done", 32'(done_cnt - dc_before), 32'd0);
      resp_const = '0;
      do_run("s5r", 15'h0001, 3, 1'b0);
      chk("s5r_v1", 32'(vq.size() > 1 ? vq[1] : '0), 32'h6000);
      check_run("s5r", 15'h0001, 3);

      // Scenario 6: start held high gives back-to-back identical runs
      fn_mode = 1'b1;
      s = STIM_W'($urandom);
      vq.delete();
      @(negedge clk);
      bus.start_i = 1'b1; bus.num_vec_i = 16'd4; bus.seed_i = s;
      @(negedge clk);
      wait_done(30, 1'b0, ok);
      chk("s6_done1", 32'(ok), 32'd1);
      d1 = done_cyc;
      sig1 = bus.signature_o;
      bus.start_i = 1'b1;
      v1 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.stim_valid_o === 1'b1) begin v1 = cyc; break; end
      end
      bus.start_i = 1'b0;
      chk("s6_restart_lat", 32'(v1 - d1), 32'd2);
      wait_done(30, 1'b0, ok);
      chk("s6_done2", 32'(ok), 32'd1);
      sig2 = bus.signature_o;
      model_run(s, 4, msig);
      chk("s6_sig1_model", 32'(sig1), 32'(msig));
      chk("s6_sig_equal", 32'(sig2), 32'(sig1));
      chk("s6_valid_total", 32'(vq.size()), 32'd8);

      // Random runs with ignored start pulses while busy
      for (int r = 0; r < 8; r++) begin
         fn_mode    = 1'($urandom_range(0, 1));
         resp_const = RESP_W'($urandom);
         s = STIM_W'($urandom);
         n = $urandom_range(1, 40);
         do_run($sformatf("rnd%0d", r), s, n, 1'b1);
         check_run($sformatf("rnd%0d", r), s, n);
      end

      // Long run against the reference model
      fn_mode = 1'b1;
      s = STIM_W'($urandom);
      do_run("long", s, 1000, 1'b0);
      check_run("long", s, 1000);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
